// File: rtl/gate_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gate_seq_pkg
//  Description : Shared types and constants for the gate sequencer slice:
//                measurement state encoding, counter count, readout header
//                size and a small integer helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package gate_seq_pkg;

    // Measurement cycle phases, in the order a single measurement visits them
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        LATCH  = 3'd4,
        SHIFT  = 3'd5,
        DONE   = 3'd6
    } gate_state_t;

    localparam int NUM_COUNTERS = 4;
    localparam int HEADER_BITS  = 4;
    localparam int SEL_WIDTH    = $clog2(NUM_COUNTERS);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : gate_sequencer_if
//  Description : Control/strobe bundle between the measurement requester
//                (master) and the gate sequencer (slave). The meas_id
//                field exists only when GATE_SEQ_MEAS_ID_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gate_sequencer_if #(
    parameter int GATE_WIDTH = 16
);
    import gate_seq_pkg::*;

    logic                  start;
    logic                  abort;
    logic                  continuous;
    logic                  scan_all;
    logic [SEL_WIDTH-1:0]  sel_in;
    logic [GATE_WIDTH-1:0] gate_len;
    logic                  ctr_reset;
    logic                  gate;
    logic                  latch_counter;
    logic [SEL_WIDTH-1:0]  counter_select;
    logic                  frame_active;
    logic                  busy;
    logic                  done;
`ifdef GATE_SEQ_MEAS_ID_EN
    logic [7:0]            meas_id;
`endif

    modport master (
        output start, abort, continuous, scan_all, sel_in, gate_len,
        input  ctr_reset, gate, latch_counter, counter_select,
               frame_active, busy, done
`ifdef GATE_SEQ_MEAS_ID_EN
        , input meas_id
`endif
    );

    modport slave (
        input  start, abort, continuous, scan_all, sel_in, gate_len,
        output ctr_reset, gate, latch_counter, counter_select,
               frame_active, busy, done
`ifdef GATE_SEQ_MEAS_ID_EN
        , output meas_id
`endif
    );

endinterface
`default_nettype wire

// File: rtl/gate_sequencer_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seq_timer
//  Description : Loadable down-counter shared by every timed phase. Load
//                the phase length minus one on phase entry; o_zero marks
//                the last cycle of the phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_timer #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_value,
    output logic                  o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load takes precedence; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gate_sequencer
//  Description : Runs one frequency measurement per request: counter clear,
//                gate window, settle gap, then latch + readout frame for one
//                counter or for all four counters off a single window.
//                Optional macro GATE_SEQ_MEAS_ID_EN adds an 8-bit
//                completed-measurement counter on meas_id.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_sequencer
    import gate_seq_pkg::*;
#(
    parameter int GATE_WIDTH    = 16,
    parameter int CLEAR_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int SHIFT_LEN     = 24
) (
    input  wire logic       clk,
    input  wire logic       reset,
    gate_sequencer_if.slave bus
);

    localparam int TIMER_WIDTH = max_int(GATE_WIDTH, $clog2(SHIFT_LEN + 1));

    localparam logic [TIMER_WIDTH-1:0] c_clear_m1  = TIMER_WIDTH'(CLEAR_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] c_settle_m1 = TIMER_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] c_shift_m1  = TIMER_WIDTH'(SHIFT_LEN - 1);
    localparam logic [SEL_WIDTH-1:0]   c_last_sel  = SEL_WIDTH'(NUM_COUNTERS - 1);
    localparam logic [SEL_WIDTH-1:0]   c_sel_one   = SEL_WIDTH'(1);
    localparam logic [GATE_WIDTH-1:0]  c_gate_one  = GATE_WIDTH'(1);

    gate_state_t            r_state;
    gate_state_t            w_state_next;
    logic                   r_scan;
    logic [SEL_WIDTH-1:0]   r_sel;
    logic [GATE_WIDTH-1:0]  r_gate_len;
    logic                   w_load;
    logic [TIMER_WIDTH-1:0] w_load_value;
    logic                   w_timer_zero;
    logic [GATE_WIDTH-1:0]  w_gate_m1;

    // A zero gate length still opens the window for one cycle
    assign w_gate_m1 = (r_gate_len == '0) ? '0 : (r_gate_len - c_gate_one);

    seq_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_value (w_load_value),
        .o_zero  (w_timer_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and timer reload for the phase being entered
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_value = '0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = CLEAR;
                    w_load       = 1'b1;
                    w_load_value = c_clear_m1;
                end
            end
            CLEAR: begin
                if (w_timer_zero) begin
                    w_state_next = GATE;
                    w_load       = 1'b1;
                    w_load_value = TIMER_WIDTH'(w_gate_m1);
                end
            end
            GATE: begin
                if (w_timer_zero) begin
                    w_state_next = SETTLE;
                    w_load       = 1'b1;
                    w_load_value = c_settle_m1;
                end
            end
            SETTLE: begin
                if (w_timer_zero) begin
                    w_state_next = LATCH;
                    w_load       = 1'b1;
                end
            end
            LATCH: begin
                w_state_next = SHIFT;
                w_load       = 1'b1;
                w_load_value = c_shift_m1;
            end
            SHIFT: begin
                if (w_timer_zero) begin
                    w_load = 1'b1;
                    if (r_scan && (r_sel != c_last_sel)) begin
                        w_state_next = LATCH;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.continuous) begin
                    w_state_next = CLEAR;
                    w_load       = 1'b1;
                    w_load_value = c_clear_m1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // Abort overrides every transition, including a continuous restart
        if (bus.abort) begin
            w_state_next = IDLE;
            w_load       = 1'b0;
        end
    end

    // Request settings capture and counter-select stepping through a scan
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan     <= 1'b0;
            r_sel      <= '0;
            r_gate_len <= '0;
        end else if ((r_state == IDLE) && (w_state_next == CLEAR)) begin
            r_scan     <= bus.scan_all;
            r_sel      <= bus.scan_all ? '0 : bus.sel_in;
            r_gate_len <= bus.gate_len;
        end else if ((r_state == SHIFT) && (w_state_next == LATCH)) begin
            r_sel <= r_sel + c_sel_one;
        end else if ((r_state == DONE) && (w_state_next == CLEAR) && r_scan) begin
            r_sel <= '0;
        end
    end

    assign bus.ctr_reset      = (r_state == CLEAR);
    assign bus.gate           = (r_state == GATE);
    assign bus.latch_counter  = (r_state == LATCH);
    assign bus.frame_active   = (r_state == SHIFT);
    assign bus.done           = (r_state == DONE);
    assign bus.busy           = (r_state != IDLE);
    assign bus.counter_select = (r_state == IDLE) ? '0 : r_sel;

`ifdef GATE_SEQ_MEAS_ID_EN
    logic [7:0] r_meas_id;

    // Count finished measurements; visible the cycle after done
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meas_id <= 8'd0;
        end else if (r_state == DONE) begin
            r_meas_id <= r_meas_id + 8'd1;
        end
    end

    assign bus.meas_id = r_meas_id;
`endif

endmodule
`default_nettype wire
